sq_op_controller: RTL and testbench

Command sequencer for the 32-entry, 16-bit stack/queue memory. It turns button presses into multi-cycle memory transactions: push, add, subtract, pop and clear. It owns the read/write pointers, element count and full/empty flags, and drives the display register. It sits between the board inputs (switches, buttons, mode switch) and a single-port synchronous-read RAM instantiated beside it in the top level.

---
 rtl/sq_op_if.sv | 30 +++
 rtl/sq_op_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_sq_op_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sq_op_if.sv
// Signal bundle between the stack/queue sequencer, the board inputs and its RAM.
// The master side is the sequencer; the slave side is the board/RAM environment.
interface sq_op_if #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 5
);
   logic                  stackQueue;
   logic [DATA_W-1:0]     switches;
   logic [4:0]            btns;
   logic [DEPTH_LOG2-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;
   logic [DATA_W-1:0]     memOut;
   logic [DEPTH_LOG2:0]   count;
   logic                  empty;
   logic                  full;
   logic                  busy;
   logic                  err;

   modport master (
      input  stackQueue, switches, btns, mem_rdata,
      output mem_addr, mem_we, mem_wdata, memOut, count, empty, full, busy, err
   );

   modport slave (
      output stackQueue, switches, btns, mem_rdata,
      input  mem_addr, mem_we, mem_wdata, memOut, count, empty, full, busy, err
   );
endinterface

// File: rtl/sq_op_controller.sv
// Command sequencer for a 32-entry stack/queue: turns button edges into push, pop,
// add, subtract and clear transactions on a single-port synchronous-read RAM.
module sq_op_controller #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic    clk,
   input  logic    rst,
   sq_op_if.master bus
);
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_TWO  = (DEPTH_LOG2+1)'(2);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_TWO  = DEPTH_LOG2'(2);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD1  = 3'd1,
      ST_RD2  = 3'd2,
      ST_CAP1 = 3'd3,
      ST_CAP2 = 3'd4,
      ST_WR   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      OP_PUSH = 2'd0,
      OP_POP  = 2'd1,
      OP_ADD  = 2'd2,
      OP_SUB  = 2'd3
   } op_t;

   state_t                state_r, state_next_s;
   op_t                   op_r, op_next_s;
   logic [4:0]            btns_q_r;
   logic [4:0]            edge_s;
   logic [4:0]            sel_s;
   logic                  mode_r, mode_next_s;
   logic [DEPTH_LOG2-1:0] head_r, head_next_s;
   logic [DEPTH_LOG2-1:0] tail_r, tail_next_s;
   logic [DEPTH_LOG2:0]   count_r, count_next_s;
   logic [DATA_W-1:0]     memout_r, memout_next_s;
   logic [DATA_W-1:0]     a_r, a_next_s;
   logic [DEPTH_LOG2-1:0] addr_r, addr_next_s;
   logic                  we_r, we_next_s;
   logic [DATA_W-1:0]     wdata_r, wdata_next_s;
   logic                  err_r, err_next_s;
   logic                  busy_r;
   logic                  empty_s, full_s;
   logic [DEPTH_LOG2-1:0] a_addr_s, b_addr_s;

   assign edge_s  = bus.btns & ~btns_q_r;
   // Isolate the lowest set bit so the lowest-indexed button wins.
   assign sel_s   = edge_s & (~edge_s + 5'd1);
   assign empty_s = (count_r == '0);
   assign full_s  = (count_r == FULL_CNT);

   // Operand A is the element removed first, B the one removed second.
   assign a_addr_s = mode_r ? head_r           : (tail_r - PTR_ONE);
   assign b_addr_s = mode_r ? (head_r + PTR_ONE) : (tail_r - PTR_TWO);

   assign bus.mem_addr  = addr_r;
   assign bus.mem_we    = we_r;
   assign bus.mem_wdata = wdata_r;
   assign bus.memOut    = memout_r;
   assign bus.count     = count_r;
   assign bus.empty     = empty_s;
   assign bus.full      = full_s;
   assign bus.busy      = busy_r;
   assign bus.err       = err_r;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and next-datapath decode
   always_comb begin
      state_next_s  = state_r;
      op_next_s     = op_r;
      mode_next_s   = mode_r;
      head_next_s   = head_r;
      tail_next_s   = tail_r;
      count_next_s  = count_r;
      memout_next_s = memout_r;
      a_next_s      = a_r;
      addr_next_s   = addr_r;
      we_next_s     = 1'b0;
      wdata_next_s  = wdata_r;
      err_next_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (empty_s) begin
               mode_next_s = bus.stackQueue;
            end else begin
               mode_next_s = mode_r;
            end
            case (sel_s)
               5'b00001: begin
                  if (!full_s) begin
                     op_next_s    = OP_PUSH;
                     state_next_s = ST_WR;
                     addr_next_s  = tail_r;
                     wdata_next_s = bus.switches;
                     we_next_s    = 1'b1;
                  end else begin
                     err_next_s = 1'b1;
                  end
               end
               5'b00010, 5'b01000: begin
                  if (count_r >= CNT_TWO) begin
                     op_next_s    = sel_s[1] ? OP_ADD : OP_SUB;
                     state_next_s = ST_RD1;
                     addr_next_s  = a_addr_s;
                  end else begin
                     err_next_s = 1'b1;
                  end
               end
               5'b00100: begin
                  if (!empty_s) begin
                     op_next_s    = OP_POP;
                     state_next_s = ST_RD1;
                     addr_next_s  = a_addr_s;
                  end else begin
                     err_next_s = 1'b1;
                  end
               end
               5'b10000: begin
                  head_next_s   = '0;
                  tail_next_s   = '0;
                  count_next_s  = '0;
                  memout_next_s = '0;
               end
               default: begin
                  state_next_s = ST_IDLE;
               end
            endcase
         end
         ST_RD1: begin
            if (op_r == OP_POP) begin
               state_next_s = ST_CAP1;
            end else begin
               state_next_s = ST_RD2;
               addr_next_s  = b_addr_s;
            end
         end
         ST_RD2: begin
            a_next_s     = bus.mem_rdata;
            state_next_s = ST_CAP2;
         end
         ST_CAP1: begin
            memout_next_s = bus.mem_rdata;
            count_next_s  = count_r - CNT_ONE;
            if (mode_r) begin
               head_next_s = head_r + PTR_ONE;
            end else begin
               tail_next_s = tail_r - PTR_ONE;
            end
            state_next_s = ST_IDLE;
         end
         ST_CAP2: begin
            if (op_r == OP_ADD) begin
               wdata_next_s = a_r + bus.mem_rdata;
            end else begin
               wdata_next_s = bus.mem_rdata - a_r;
            end
            // Queue appends the result at tail; stack overwrites the B slot.
            addr_next_s  = mode_r ? tail_r : (tail_r - PTR_TWO);
            we_next_s    = 1'b1;
            state_next_s = ST_WR;
         end
         ST_WR: begin
            memout_next_s = wdata_r;
            if (op_r == OP_PUSH) begin
               tail_next_s  = tail_r + PTR_ONE;
               count_next_s = count_r + CNT_ONE;
            end else if (mode_r) begin
               head_next_s  = head_r + PTR_TWO;
               tail_next_s  = tail_r + PTR_ONE;
               count_next_s = count_r - CNT_ONE;
            end else begin
               tail_next_s  = tail_r - PTR_ONE;
               count_next_s = count_r - CNT_ONE;
            end
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Datapath, pointer and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btns_q_r <= 5'd0;
         op_r     <= OP_PUSH;
         mode_r   <= 1'b0;
         head_r   <= '0;
         tail_r   <= '0;
         count_r  <= '0;
         memout_r <= '0;
         a_r      <= '0;
         addr_r   <= '0;
         we_r     <= 1'b0;
         wdata_r  <= '0;
         err_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         btns_q_r <= bus.btns;
         op_r     <= op_next_s;
         mode_r   <= mode_next_s;
         head_r   <= head_next_s;
         tail_r   <= tail_next_s;
         count_r  <= count_next_s;
         memout_r <= memout_next_s;
         a_r      <= a_next_s;
         addr_r   <= addr_next_s;
         we_r     <= we_next_s;
         wdata_r  <= wdata_next_s;
         err_r    <= err_next_s;
         busy_r   <= (state_next_s != ST_IDLE);
      end
   end
endmodule

// File: tb/tb_sq_op_controller.sv
// Self-checking bench for sq_op_controller: directed table, corner sequences and
// randomized commands against a list-based model of the stack/queue contents.
module tb_sq_op_controller;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   sq_op_if #(.DATA_W(16), .DEPTH_LOG2(5)) bus ();

   sq_op_controller #(.DATA_W(16), .DEPTH_LOG2(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] ram [32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   typedef struct {
      logic [4:0]  mask;
      logic [15:0] sw;
      logic        sq;
      logic [15:0] e_mem;
      int          e_cnt;
      logic        e_err;
   } vec_t;

   vec_t tbl [22];

   // Reference model: contents listed oldest-first, top of stack at the back
   logic [15:0] q_m [$];
   logic        mode_m;
   logic [15:0] memout_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int low_idx(input logic [4:0] mask);
      int idx = -1;
      for (int i = 4; i >= 0; i--) if (mask[i]) idx = i;
      return idx;
   endfunction

   function automatic int lat_of(input int idx);
      case (idx)
         0:       return 1;
         2:       return 2;
         1, 3:    return 4;
         default: return 0;
      endcase
   endfunction

   task automatic run_cmd(input string name, input logic [4:0] mask, input logic [15:0] sw,
                          input logic sq, input logic [15:0] e_mem, input int e_cnt,
                          input logic e_err, input int e_busy, input int e_we);
      logic err1, err2;
      int   nb, nwe;
      err1 = 1'b0; err2 = 1'b0; nb = 0; nwe = 0;
      bus.btns = mask; bus.switches = sw; bus.stackQueue = sq;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            err1 = bus.err;
            bus.btns = 5'd0;
         end
         if (k == 2) err2 = bus.err;
         if (bus.busy) nb++;
         if (bus.mem_we) nwe++;
      end
      chk({name, " memOut"}, 32'(bus.memOut), 32'(e_mem));
      chk({name, " count"}, 32'(bus.count), 32'(e_cnt));
      chk({name, " empty"}, 32'(bus.empty), 32'(e_cnt == 0));
      chk({name, " full"}, 32'(bus.full), 32'(e_cnt == 32));
      chk({name, " err"}, 32'(err1), 32'(e_err));
      chk({name, " err_width"}, 32'(err2), 32'd0);
      chk({name, " busy_cycles"}, 32'(nb), 32'(e_busy));
      chk({name, " we_cycles"}, 32'(nwe), 32'(e_we));
   endtask

   task automatic model_cmd(input logic [4:0] mask, input logic [15:0] sw, input logic sq,
                            output logic e_err, output int e_busy, output int e_we);
      int idx;
      logic [15:0] a, b, r;
      idx = low_idx(mask);
      e_err = 1'b0; e_busy = 0; e_we = 0;
      if (q_m.size() == 0) mode_m = sq;
      if (idx == 0) begin
         if (q_m.size() < 32) begin
            q_m.push_back(sw); memout_m = sw; e_busy = 1; e_we = 1;
         end else e_err = 1'b1;
      end else if (idx == 1 || idx == 3) begin
         if (q_m.size() >= 2) begin
            a = mode_m ? q_m.pop_front() : q_m.pop_back();
            b = mode_m ? q_m.pop_front() : q_m.pop_back();
            r = (idx == 1) ? a + b : b - a;
            q_m.push_back(r); memout_m = r; e_busy = 4; e_we = 1;
         end else e_err = 1'b1;
      end else if (idx == 2) begin
         if (q_m.size() >= 1) begin
            memout_m = mode_m ? q_m.pop_front() : q_m.pop_back(); e_busy = 2;
         end else e_err = 1'b1;
      end else if (idx == 4) begin
         q_m.delete(); memout_m = 16'd0;
      end
   endtask

   initial begin
      logic        e_err;
      int          e_busy, e_we, r;
      logic [4:0]  mask;
      logic [15:0] sw;
      logic        sq;

      n_chk = 0; n_fail = 0;
      mode_m = 1'b0; memout_m = 16'd0;
      bus.btns = 5'd0; bus.switches = 16'd0; bus.stackQueue = 1'b0;

      tbl[0]  = '{5'b10000, 16'd0,  1'b0, 16'd0,      0, 1'b0};
      tbl[1]  = '{5'b00100, 16'd0,  1'b0, 16'd0,      0, 1'b1};
      tbl[2]  = '{5'b00010, 16'd0,  1'b0, 16'd0,      0, 1'b1};
      tbl[3]  = '{5'b00001, 16'd10, 1'b0, 16'd10,     1, 1'b0};
      tbl[4]  = '{5'b00010, 16'd0,  1'b0, 16'd10,     1, 1'b1};
      tbl[5]  = '{5'b00001, 16'd3,  1'b0, 16'd3,      2, 1'b0};
      tbl[6]  = '{5'b01000, 16'd0,  1'b0, 16'd7,      1, 1'b0};
      tbl[7]  = '{5'b10000, 16'd0,  1'b0, 16'd0,      0, 1'b0};
      tbl[8]  = '{5'b00001, 16'd3,  1'b0, 16'd3,      1, 1'b0};
      tbl[9]  = '{5'b00001, 16'd10, 1'b0, 16'd10,     2, 1'b0};
      tbl[10] = '{5'b01000, 16'd0,  1'b0, 16'hFFF9,   1, 1'b0};
      tbl[11] = '{5'b00100, 16'd0,  1'b0, 16'hFFF9,   0, 1'b0};
      tbl[12] = '{5'b10000, 16'd0,  1'b1, 16'd0,      0, 1'b0};
      tbl[13] = '{5'b00001, 16'd1,  1'b1, 16'd1,      1, 1'b0};
      tbl[14] = '{5'b00001, 16'd2,  1'b0, 16'd2,      2, 1'b0};
      tbl[15] = '{5'b00001, 16'd3,  1'b0, 16'd3,      3, 1'b0};
      tbl[16] = '{5'b00001, 16'd4,  1'b0, 16'd4,      4, 1'b0};
      tbl[17] = '{5'b00010, 16'd0,  1'b0, 16'd3,      3, 1'b0};
      tbl[18] = '{5'b00100, 16'd0,  1'b0, 16'd3,      2, 1'b0};
      tbl[19] = '{5'b01100, 16'd0,  1'b0, 16'd4,      1, 1'b0};
      tbl[20] = '{5'b00100, 16'd0,  1'b0, 16'd3,      0, 1'b0};
      tbl[21] = '{5'b00110, 16'd0,  1'b0, 16'd3,      0, 1'b1};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset memOut", 32'(bus.memOut), 32'd0);
      chk("reset count", 32'(bus.count), 32'd0);
      chk("reset empty", 32'(bus.empty), 32'd1);
      chk("reset full", 32'(bus.full), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset err", 32'(bus.err), 32'd0);
      chk("reset mem_we", 32'(bus.mem_we), 32'd0);
      chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 22; i++) begin
         run_cmd($sformatf("vec%0d", i), tbl[i].mask, tbl[i].sw, tbl[i].sq, tbl[i].e_mem,
                 tbl[i].e_cnt, tbl[i].e_err,
                 tbl[i].e_err ? 0 : lat_of(low_idx(tbl[i].mask)),
                 (tbl[i].e_err || low_idx(tbl[i].mask) == 2 || low_idx(tbl[i].mask) == 4) ? 0 : 1);
      end

      // Fill a stack, overflow it, then fold it down with adds
      run_cmd("stk_clr", 5'b10000, 16'd0, 1'b0, 16'd0, 0, 1'b0, 0, 0);
      for (int i = 1; i <= 32; i++)
         run_cmd($sformatf("stk_push%0d", i), 5'b00001, 16'(i), 1'b0, 16'(i), i, 1'b0, 1, 1);
      run_cmd("stk_push33", 5'b00001, 16'd33, 1'b0, 16'd32, 32, 1'b1, 0, 0);
      for (int k = 1; k <= 31; k++)
         run_cmd($sformatf("stk_add%0d", k), 5'b00010, 16'd0, 1'b0,
                 16'(528 - ((31 - k) * (32 - k)) / 2), 32 - k, 1'b0, 4, 1);
      run_cmd("stk_add_err", 5'b00010, 16'd0, 1'b0, 16'h0210, 1, 1'b1, 0, 0);

      // Queue wrap-around: pointers pass the end of the array
      run_cmd("q_clr", 5'b10000, 16'd0, 1'b1, 16'd0, 0, 1'b0, 0, 0);
      for (int i = 1; i <= 32; i++)
         run_cmd($sformatf("q_push%0d", i), 5'b00001, 16'(i), 1'b1, 16'(i), i, 1'b0, 1, 1);
      for (int i = 1; i <= 16; i++)
         run_cmd($sformatf("q_pop%0d", i), 5'b00100, 16'd0, 1'b1, 16'(i), 32 - i, 1'b0, 2, 0);
      for (int i = 1; i <= 16; i++)
         run_cmd($sformatf("q_repush%0d", i), 5'b00001, 16'(32 + i), 1'b1, 16'(32 + i),
                 16 + i, 1'b0, 1, 1);
      for (int i = 1; i <= 32; i++)
         run_cmd($sformatf("q_drain%0d", i), 5'b00100, 16'd0, 1'b1, 16'(16 + i), 32 - i,
                 1'b0, 2, 0);

      // Asynchronous reset in the middle of an add
      run_cmd("rs_clr", 5'b10000, 16'd0, 1'b0, 16'd0, 0, 1'b0, 0, 0);
      run_cmd("rs_push5", 5'b00001, 16'd5, 1'b0, 16'd5, 1, 1'b0, 1, 1);
      run_cmd("rs_push6", 5'b00001, 16'd6, 1'b0, 16'd6, 2, 1'b0, 1, 1);
      bus.btns = 5'b00010;
      @(negedge clk);
      bus.btns = 5'd0;
      @(negedge clk);
      chk("rs_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("rs memOut", 32'(bus.memOut), 32'd0);
      chk("rs count", 32'(bus.count), 32'd0);
      chk("rs empty", 32'(bus.empty), 32'd1);
      chk("rs busy", 32'(bus.busy), 32'd0);
      chk("rs mem_we", 32'(bus.mem_we), 32'd0);
      chk("rs mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rs mem_wdata", 32'(bus.mem_wdata), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_cmd("rs_push9", 5'b00001, 16'd9, 1'b0, 16'd9, 1, 1'b0, 1, 1);

      // Randomized commands against the model
      model_cmd(5'b10000, 16'd0, 1'b0, e_err, e_busy, e_we);
      run_cmd("rnd_clr", 5'b10000, 16'd0, 1'b0, memout_m, q_m.size(), e_err, e_busy, e_we);
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(99);
         if (r < 45)      mask = 5'b00001;
         else if (r < 60) mask = 5'b00100;
         else if (r < 72) mask = 5'b00010;
         else if (r < 84) mask = 5'b01000;
         else if (r < 87) mask = 5'b10000;
         else             mask = 5'($urandom_range(31));
         sw = 16'($urandom);
         sq = 1'($urandom_range(1));
         model_cmd(mask, sw, sq, e_err, e_busy, e_we);
         run_cmd($sformatf("rnd%0d", n), mask, sw, sq, memout_m, q_m.size(), e_err, e_busy, e_we);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
